// File: rtl/inst_queue.sv
// Instruction queue between fetch and the two decode slots.
// Circular buffer taking up to two pushes and two pops per cycle.
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [1:0]   in_valid,
    input  logic [31:0]  in_inst0,
    input  logic [31:0]  in_inst1,
    input  logic [31:0]  in_pc0,
    input  logic [31:0]  in_pc1,
    input  logic [31:0]  in_pc_next0,
    input  logic [31:0]  in_pc_next1,
    input  logic [6:0]   in_exception0,
    input  logic [6:0]   in_exception1,
    output logic         in_ready,
    output logic [102:0] out_packet0,
    output logic [102:0] out_packet1,
    output logic [1:0]   out_valid,
    input  logic [1:0]   out_accept
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h03400000;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] np;
    logic [CW-1:0] nc;
    logic          push0;
    logic          push1;
    logic          pop0;
    logic          pop1;
    logic          clear;
    logic [102:0]  pack0;
    logic [102:0]  pack1;
    logic [102:0]  mem [DEPTH];

    // Faulting fetches carry a NOP so decode raises no spurious illegal-inst.
    function automatic logic [102:0] pack(
        input logic [6:0]  exc,
        input logic [31:0] pc_next,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        logic [31:0] word;
        word = (exc != 7'd0) ? NOP : inst;
        return {exc, pc_next, pc, word};
    endfunction

    assign clear   = rst | flush;
    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    assign in_ready     = (count <= CW'(DEPTH - 2));
    assign out_valid[0] = (count != CW'(0));
    assign out_valid[1] = (count > CW'(1));

    assign push0 = in_ready & in_valid[0];
    assign push1 = push0 & in_valid[1];
    assign pop0  = out_accept[0] & out_valid[0];
    assign pop1  = pop0 & out_accept[1] & out_valid[1];

    assign np = CW'(push0) + CW'(push1);
    assign nc = CW'(pop0) + CW'(pop1);

    assign pack0 = pack(in_exception0, in_pc_next0, in_pc0, in_inst0);
    assign pack1 = pack(in_exception1, in_pc_next1, in_pc1, in_inst1);

    assign out_packet0 = mem[head];
    assign out_packet1 = mem[head_p1];

    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + nc[AW-1:0];
            tail  <= tail + np[AW-1:0];
            count <= count + np - nc;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push0) mem[tail] <= pack0;
            if (push1) mem[tail_p1] <= pack1;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   in_valid;
    logic [31:0]  in_inst0, in_inst1;
    logic [31:0]  in_pc0, in_pc1;
    logic [31:0]  in_pc_next0, in_pc_next1;
    logic [6:0]   in_exception0, in_exception1;
    logic         in_ready;
    logic [102:0] out_packet0, out_packet1;
    logic [1:0]   out_valid;
    logic [1:0]   out_accept;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid),
        .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_pc_next0(in_pc_next0), .in_pc_next1(in_pc_next1),
        .in_exception0(in_exception0), .in_exception1(in_exception1),
        .in_ready(in_ready),
        .out_packet0(out_packet0), .out_packet1(out_packet1),
        .out_valid(out_valid), .out_accept(out_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [102:0] q[$];

    typedef struct {
        logic       fl;
        logic [1:0] iv;
        logic [1:0] oa;
        logic [1:0] ev;
        logic       ir;
    } vec_t;

    function automatic logic [102:0] expect_pack(
        input logic [6:0] e, input logic [31:0] pn,
        input logic [31:0] p, input logic [31:0] i);
        return {e, pn, p, (e != 7'd0) ? 32'h03400000 : i};
    endfunction

    task automatic chk(input string name, input logic [102:0] act,
                       input logic [102:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ev;
        ev = {q.size() >= 2, q.size() >= 1};
        chk("out_valid", 103'(out_valid), 103'(ev));
        chk("in_ready", 103'(in_ready), 103'((DEPTH - q.size()) >= 2));
        if (q.size() >= 1) chk("out_packet0", out_packet0, q[0]);
        if (q.size() >= 2) chk("out_packet1", out_packet1, q[1]);
    endtask

    // Model: apply this cycle's inputs, clock, then compare outputs.
    task automatic step();
        int sz, nc, np;
        logic [102:0] p0, p1;
        p0 = expect_pack(in_exception0, in_pc_next0, in_pc0, in_inst0);
        p1 = expect_pack(in_exception1, in_pc_next1, in_pc1, in_inst1);
        if (rst || flush) begin
            q.delete();
        end else begin
            sz = q.size();
            nc = 0;
            np = 0;
            if (out_accept[0] && sz >= 1)
                nc = (out_accept[1] && sz >= 2) ? 2 : 1;
            if (in_valid[0] && (DEPTH - sz) >= 2)
                np = in_valid[1] ? 2 : 1;
            repeat (nc) void'(q.pop_front());
            if (np >= 1) q.push_back(p0);
            if (np == 2) q.push_back(p1);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_data();
        in_inst0      = $urandom;
        in_inst1      = $urandom;
        in_pc0        = $urandom;
        in_pc1        = in_pc0 + 32'd4;
        in_pc_next0   = in_pc1;
        in_pc_next1   = in_pc1 + 32'd4;
        in_exception0 = ($urandom_range(3) == 0) ? 7'($urandom_range(127, 1)) : 7'd0;
        in_exception1 = ($urandom_range(3) == 0) ? 7'($urandom_range(127, 1)) : 7'd0;
    endtask

    vec_t vecs[13];
    logic [31:0] pc;

    initial begin
        vecs[0]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b1};
        vecs[1]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b1};
        vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b1};
        vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 2'b11, 2'b11, 1'b1};
        vecs[6]  = '{1'b0, 2'b01, 2'b01, 2'b11, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 2'b10, 2'b11, 1'b1};
        vecs[8]  = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1};
        vecs[10] = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b1};
        vecs[11] = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b1};
        vecs[12] = '{1'b0, 2'b11, 2'b11, 2'b11, 1'b1};

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 2'b00;
        out_accept = 2'b00;
        rand_data();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_out_valid", 103'(out_valid), 103'(2'b00));
        chk("reset_in_ready", 103'(in_ready), 103'(1'b1));

        // Basic pair push
        in_valid = 2'b11;
        in_inst0 = 32'h02800421; in_pc0 = 32'h1c000000;
        in_pc_next0 = 32'h1c000004; in_exception0 = 7'd0;
        in_inst1 = 32'h02800842; in_pc1 = 32'h1c000004;
        in_pc_next1 = 32'h1c000008; in_exception1 = 7'd0;
        step();
        chk("pair_valid", 103'(out_valid), 103'(2'b11));
        chk("pair_pc0", 103'(out_packet0[63:32]), 103'(32'h1c000000));
        chk("pair_inst1", 103'(out_packet1[31:0]), 103'(32'h02800842));

        // Exception forces NOP while popping the pair
        in_valid = 2'b01;
        out_accept = 2'b11;
        in_inst0 = 32'hffffffff; in_pc0 = 32'h1c000008;
        in_pc_next0 = 32'h1c00000c; in_exception0 = 7'h08;
        step();
        chk("exc_packet", out_packet0,
            {7'h08, 32'h1c00000c, 32'h1c000008, 32'h03400000});
        chk("exc_valid", 103'(out_valid), 103'(2'b01));

        flush = 1'b1;
        in_valid = 2'b00;
        out_accept = 2'b00;
        step();
        flush = 1'b0;

        foreach (vecs[i]) begin
            flush = vecs[i].fl;
            in_valid = vecs[i].iv;
            out_accept = vecs[i].oa;
            rand_data();
            step();
            chk($sformatf("vec%0d_out_valid", i), 103'(out_valid), 103'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), 103'(in_ready), 103'(vecs[i].ir));
        end

        // Wrap: one in, one out per cycle, sequential PCs
        flush = 1'b1;
        step();
        flush = 1'b0;
        pc = 32'h00001000;
        in_valid = 2'b01;
        out_accept = 2'b00;
        rand_data();
        in_exception0 = 7'd0;
        in_pc0 = pc;
        step();
        out_accept = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            rand_data();
            in_exception0 = 7'd0;
            in_pc0 = pc + 32'(4 * i);
            step();
            chk($sformatf("wrap%0d_pc", i), 103'(out_packet0[63:32]),
                103'(pc + 32'(4 * i)));
            chk($sformatf("wrap%0d_valid", i), 103'(out_valid), 103'(2'b01));
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            in_valid = 2'($urandom);
            out_accept = 2'($urandom);
            flush = ($urandom_range(49) == 0);
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the two decode slots. It accepts up to two fetched instructions per cycle, each with its PC, predicted next PC and 7-bit fetch exception code, and stores them in a circular buffer. It presents the two oldest entries to the decoders as 103-bit packets `{exception[6:0], pc_next[31:0], pc[31:0], inst[31:0]}`. It also absorbs fetch/decode rate mismatch and is cleared by pipeline flushes.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥4.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all entries; synchronous.
- `in_valid`  in  2  fetch slots valid; bit1 honoured only if bit0 set.
- `in_inst0/1`  in  32 each  instruction words.
- `in_pc0/1`  in  32 each  instruction PCs.
- `in_pc_next0/1`  in  32 each  predicted next PCs.
- `in_exception0/1`  in  7 each  fetch exception codes; 0 = none.
- `in_ready`  out  1  queue can take two instructions this cycle.
- `out_packet0/1`  out  103 each  head and head+1 packets.
- `out_valid`  out  2  bit0: ≥1 entry; bit1: ≥2 entries.
- `out_accept`  in  2  decode consumes; bit1 honoured only if bit0 set and `out_valid[1]`.

## Operation
- State: `head`, `tail` (log2(DEPTH) bits, wrap modulo DEPTH), `count` (log2(DEPTH)+1 bits), storage array DEPTH×103 (not reset).
- Push count `np` = 0 if `!in_ready` or `!in_valid[0]`; otherwise 1 + `in_valid[1]`.
- Slot0 writes to `tail`, slot1 to `tail+1` (mod DEPTH); `tail += np`.
- Pop count `nc` = `out_accept[0]&out_valid[0]` + `out_accept[0]&out_accept[1]&out_valid[1]`; `head += nc`.
- `count <= count + np - nc`. Simultaneous push and pop allowed in the same cycle.
- Packing: if `in_exception≠0`, the stored inst field is forced to 32'h03400000 (NOP) so decode flags no spurious illegal instruction. The exception, pc and pc_next fields are stored unmodified.
- `in_ready` = (DEPTH − `count`) ≥ 2, from registered `count` only. There is no same-cycle credit from a pop.
- `out_packet0` = storage[`head`]; `out_packet1` = storage[`head+1`]. These are combinational reads and are don't-care when the matching `out_valid` bit is low.
- `flush` (or `rst`): `head`, `tail`, `count` ← 0. Pushes and pops in that cycle are discarded. `rst` has priority; `flush` and `rst` act identically on state.
- `in_valid=2'b10` or `out_accept=2'b10` is treated as 0 for that cycle.

## Timing
- Reset values: `count=0`, `out_valid=2'b00`, `in_ready=1`, `head=tail=0`.
- Latency: an instruction pushed in cycle N appears on `out_packet*` with `out_valid` in cycle N+1. There is no input-to-output bypass.
- Pop in cycle N frees space visible on `in_ready` in cycle N+1.
- Full (`count=DEPTH`) and `count=DEPTH−1`: `in_ready=0`; all inputs ignored.
- Empty: `out_valid=0`, `out_accept` ignored. With `count=1`, only bit0 is consumed.
- Wrap-around: pair writes and reads straddling index DEPTH−1→0 are contiguous in program order.
- Flush mid-stream: cycle after `flush`, `out_valid=0`, `in_ready=1`. Fetch data presented in the flush cycle is lost.
- Order: `out_packet0` is always older than `out_packet1`; slot0 of a push is older than slot1.

## Test plan
- Reset, then push pair {inst=0x02800421, pc=0x1c000000, pc_next=0x1c000004, exc=0} and {0x02800842, 0x1c000004, 0x1c000008, 0} in cycle 1 → cycle 2 `out_valid=2'b11`, `out_packet0[63:32]=0x1c000000`, `out_packet1[31:0]=0x02800842`.
- Push exc0=7'h08 with inst=0xffffffff → stored packet has inst 0x03400000, exception 0x08, pc/pc_next unchanged.
- DEPTH=8: push 3 pairs, no pops → `count=6`, `in_ready=1`; push 1 more pair → `count=8`, `in_ready=0`. A further push is ignored and contents are unchanged. Pop 2 → `in_ready=1` the next cycle.
- Wrap: push/pop 1 per cycle for 20 cycles with sequential PCs → outputs in strict PC order, `count` constant at 1, no loss across index 7→0.
- Full queue with `flush`, `in_valid=2'b11` and `out_accept=2'b11` in the same cycle → next cycle `out_valid=0`, `count=0`, `in_ready=1`; the flushed-cycle inputs never appear.
- `count=1`, `out_accept=2'b11` and a simultaneous pair push → next cycle `count=2`, head advanced by exactly 1.
